branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the decode stage of the pipelined MIPS core. It accepts one conditional branch at a time from decode and stalls fetch/decode until the operands it needs are available from the forwarding network. It then evaluates the condition (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ) and issues a one-cycle registered redirect to fetch when the branch is taken. The delay-slot instruction is never squashed.

## Interface
- MAX_WAIT, 8: operand-wait cycles before `wait_err` is raised; legal range 2..255.
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- br_valid  in  1  decode holds a branch; held stable while `stall`=1.
- br_op  in  3  branch opcode: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6/7 reserved.
- rs_val  in  32  forwarded rs value.
- rt_val  in  32  forwarded rt value.
- rs_ready  in  1  rs_val is final this cycle.
- rt_ready  in  1  rt_val is final this cycle.
- br_target  in  32  precomputed branch target PC.
- flush  in  1  exception/eret flush; highest priority.
- stall  out  1  hold PC and IF/ID register.
- redirect_valid  out  1  one-cycle pulse: fetch loads `redirect_pc`.
- redirect_pc  out  32  taken target.
- br_done  out  1  one-cycle pulse: a branch was resolved, taken or not.
- wait_err  out  1  sticky flag: operand wait reached MAX_WAIT; cleared by reset only.

## Operation
- States: IDLE, WAIT, REDIRECT.
- Operands needed:
  - BEQ/BNE need rs and rt.
  - All other opcodes need rs only.
  - `ops_ready` = AND of the ready flags for the needed operands.
- Conditions use signed 32-bit compares against 0; BEQ/BNE use full 32-bit equality. Reserved opcodes resolve not-taken with no error.
- IDLE:
  - `br_valid` & `ops_ready`: resolve this cycle. If taken, latch `br_target` and go to REDIRECT; otherwise stay in IDLE.
  - `br_valid` & !`ops_ready`: go to WAIT; wait counter is set to 1.
- WAIT:
  - `ops_ready`: resolve exactly as in IDLE.
  - Otherwise: counter increments, saturating at MAX_WAIT. Counter reaching MAX_WAIT sets `wait_err`; the block stays in WAIT.
- REDIRECT:
  - `redirect_valid`=1 for this single cycle.
  - A `br_valid` present in this cycle is not evaluated; it is handled from IDLE on the next cycle.
  - Next state is IDLE.
- flush: forces IDLE, clears the counter and `redirect_pc` latch validity, and suppresses `redirect_valid`/`br_done` in the same cycle. `wait_err` is kept.

## Timing
- Reset values: state IDLE, `stall` 0, `redirect_valid` 0, `redirect_pc` 0, `br_done` 0, `wait_err` 0, counter 0, stats counters 0.
- `stall` is combinational: (IDLE|WAIT) & `br_valid` & !`ops_ready` & !`flush`, or REDIRECT & `br_valid`.
- `br_done` is registered. It pulses the cycle after the resolve cycle.
- `redirect_valid`/`redirect_pc` are registered, with the same one-cycle latency. The delay slot is fetched in the resolve cycle.
- Ready operands: zero stall cycles, redirect at cycle N+1.
- Operands that become ready k cycles late: `stall` high for k cycles, redirect at N+k+1.
- `flush` together with `ops_ready`: the flush wins and nothing resolves.
- `reset_n` low mid-WAIT or mid-REDIRECT: all outputs drop immediately (asynchronous).

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs `taken_cnt` [31:0] and `ntaken_cnt` [31:0].
  - One of the two increments on each `br_done`, wrapping at 2^32.
  - Both counters reset to 0.
- BRANCH_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Structure
- Package `branch_pkg`: opcode constants BR_BEQ..BR_BGEZ, the state enum (IDLE/WAIT/REDIRECT), and the default for MAX_WAIT.
- Sub-module `branch_cond`: combinational; inputs `br_op`, `rs_val`, `rt_val`; outputs `taken` and `needs_rt`.
- `branch_ctrl` contains the FSM, wait counter, output registers and optional stats.

## Test plan
- BEQ, rs=rt=0x1234, both ready -> `stall` 0; next cycle `redirect_valid`=1, `redirect_pc`=`br_target`, `br_done`=1.
- BLTZ, rs=0x80000000, rs_ready low for 3 cycles -> `stall` high 3 cycles; redirect asserted one cycle after ready.
- BGEZ, rs=0xFFFFFFFF, ready -> `br_done`=1, `redirect_valid`=0 (not taken); BNE with rt_ready=0 but rs=rt -> stalls until rt_ready, then not taken.
- BGTZ with rs_ready held low for MAX_WAIT=8 cycles -> `wait_err`=1 at the 8th stall cycle and stays set after a later flush.
- Taken BEQ with `flush`=1 in the resolve cycle -> no `redirect_valid`, no `br_done`, state IDLE; then `reset_n` pulsed low mid-WAIT -> all outputs 0 immediately.
- BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> `taken_cnt`=3, `ntaken_cnt`=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the decode-stage branch resolution controller:
// opcode encodings, FSM state type and the default operand-wait limit.
package branch_pkg;

  localparam int MAX_WAIT_DEF = 8;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLEZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides taken/not-taken and reports whether
// the opcode depends on rt. Reserved opcodes resolve not-taken.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken,
  output logic        needs_rt
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_val == 32'd0);
  assign rs_neg  = rs_val[31];

  always_comb begin
    taken    = 1'b0;
    needs_rt = 1'b0;
    unique case (br_op)
      BR_BEQ: begin
        needs_rt = 1'b1;
        taken    = (rs_val == rt_val);
      end
      BR_BNE: begin
        needs_rt = 1'b1;
        taken    = (rs_val != rt_val);
      end
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = ~rs_neg & ~rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = ~rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch resolution FSM with operand-wait timer and registered
// redirect. Define BRANCH_STATS_EN to add taken/not-taken counters.
//
// state    | meaning
// IDLE     | no branch pending; resolves immediately when operands are ready
// WAIT     | branch held in decode, waiting on forwarded operands
// REDIRECT | redirect pulse cycle; any presented branch is held off
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        br_valid,
  input  logic [2:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic [31:0] br_target,
  input  logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        br_done,
  output logic        wait_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] ntaken_cnt
`endif
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q;
  logic [31:0] pc_q;
  logic        err_q;
  logic        taken;
  logic        needs_rt;
  logic        ops_ready;
  logic        resolve;

  branch_cond u_cond (
    .br_op   (br_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .taken   (taken),
    .needs_rt(needs_rt)
  );

  assign ops_ready = rs_ready & (rt_ready | ~needs_rt);

  assign stall = (state_q == REDIRECT) ? br_valid
                                       : (br_valid & ~ops_ready & ~flush);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resolve = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (ops_ready) begin
            resolve = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      WAIT: begin
        if (!br_valid) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (ops_ready) begin
          resolve = 1'b1;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (resolve && taken) state_d = REDIRECT;
    // flush outranks everything, including a resolve in the same cycle
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      resolve = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      pc_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= resolve;
      if (resolve && taken) pc_q <= br_target;
      if (cnt_d == MAX_CNT) err_q <= 1'b1;
    end
  end

  // a taken resolve always lands in REDIRECT, so the state doubles as the pulse
  assign redirect_valid = (state_q == REDIRECT) & ~flush;
  assign br_done        = done_q & ~flush;
  assign redirect_pc    = pc_q;
  assign wait_err       = err_q;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt  <= 32'd0;
      ntaken_cnt <= 32'd0;
    end else if (br_done) begin
      if (state_q == REDIRECT) taken_cnt  <= taken_cnt + 32'd1;
      else                     ntaken_cnt <= ntaken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized scoreboard bench for branch_ctrl against a cycle-level
// reference built from the branch rules; covers BRANCH_STATS_EN when defined.
module tb_branch_ctrl;
  import branch_pkg::*;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        rs_ready = 1'b0;
  logic        rt_ready = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        br_done;
  logic        wait_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] ntaken_cnt;
`endif

  branch_ctrl #(.MAX_WAIT(MW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .br_valid      (br_valid),
    .br_op         (br_op),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .rs_ready      (rs_ready),
    .rt_ready      (rt_ready),
    .br_target     (br_target),
    .flush         (flush),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .br_done       (br_done),
    .wait_err      (wait_err)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .ntaken_cnt    (ntaken_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          taken;
    logic [31:0] pc;
  } exp_t;
  exp_t sbq[$];

  // reference state: what the outputs must show in the current cycle
  bit m_redir, m_done_now, m_rv_now, m_err, m_resolved;
  int m_stallrun;
  int n_taken, n_ntaken;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) <= 0;
      3: return $signed(a) > 0;
      4: return $signed(a) < 0;
      5: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    m_redir = 0; m_done_now = 0; m_rv_now = 0; m_err = 0;
    m_resolved = 0; m_stallrun = 0; n_taken = 0; n_ntaken = 0;
    sbq.delete();
  endtask

  // Called once per cycle after inputs settle: checks outputs, advances model.
  task automatic step();
    bit ready, exp_stall, resolve, tk;
    ready = br_valid && rs_ready && (rt_ready || (int'(br_op) > 1));
    exp_stall = br_valid && (m_redir || (!ready && !flush));
    check("stall", stall, exp_stall);
    check("br_done", br_done, m_done_now);
    check("redirect_valid_cycle", redirect_valid, m_rv_now);
    check("wait_err", wait_err, m_err);
    resolve = !m_redir && br_valid && ready && !flush;
    tk = ref_taken(int'(br_op), rs_val, rt_val);
    if (resolve) begin
      sbq.push_back('{taken: tk, pc: br_target});
      if (tk) n_taken++; else n_ntaken++;
    end
    if (flush || m_redir || !br_valid || ready) m_stallrun = 0;
    else begin
      m_stallrun++;
      if (m_stallrun >= MW) m_err = 1;
    end
    m_resolved = resolve;
    m_done_now = resolve;
    m_rv_now   = resolve && tk;
    m_redir    = resolve && tk;
  endtask

  task automatic idle(input int n, input bit allow_flush);
    for (int i = 0; i < n; i++) begin
      br_valid = 1'b0;
      rs_ready = 1'($urandom_range(0, 1));
      rt_ready = 1'($urandom_range(0, 1));
      flush = allow_flush && !m_done_now && ($urandom_range(0, 5) == 0);
      #1 step();
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  task automatic run_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] tgt, input int drs, input int drt,
                        input bit allow_flush);
    int cyc = 0;
    br_valid = 1'b1; br_op = op; rs_val = a; rt_val = b; br_target = tgt;
    do begin
      rs_ready = (cyc >= drs);
      rt_ready = (cyc >= drt);
      flush = allow_flush && !m_done_now && ($urandom_range(0, 7) == 0);
      #1 step();
      @(negedge clk);
      cyc++;
    end while (!m_resolved && cyc < 60);
    if (!m_resolved) begin
      miscompares++;
      $display("FAIL resolve_timeout: op %0d never resolved", op);
    end
    br_valid = 1'b0;
    flush = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && br_done) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_br_done: got 1 expected 0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          check("redirect_valid", redirect_valid, e.taken);
          if (e.taken) check("redirect_pc", redirect_pc, e.pc);
        end
      end
    end
  end

  initial begin : driver
    logic [2:0]  op;
    logic [31:0] a, b;
    model_clear();
    #12;
    check("rst_stall", stall, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_br_done", br_done, 0);
    check("rst_wait_err", wait_err, 0);
`ifdef BRANCH_STATS_EN
    check("rst_taken_cnt", taken_cnt, 0);
    check("rst_ntaken_cnt", ntaken_cnt, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    idle(2, 0);

    run_br(BR_BEQ,  32'h1234, 32'h1234, 32'h0040_0100, 0, 0, 0);
    idle(1, 0);
    run_br(BR_BLTZ, 32'h8000_0000, 32'd0, 32'h0040_0200, 3, 0, 0);
    idle(1, 0);
    run_br(BR_BGEZ, 32'hFFFF_FFFF, 32'd0, 32'h0040_0300, 0, 0, 0);
    run_br(BR_BNE,  32'h55, 32'h55, 32'h0040_0400, 0, 2, 0);
    idle(2, 0);

    for (int t = 0; t < 60; t++) begin
      op = 3'($urandom_range(0, 7));
      a = pick_val();
      b = ($urandom_range(0, 1) == 1) ? a : pick_val();
      run_br(op, a, b, $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 3), $urandom_range(0, 3), 1);
      idle($urandom_range(0, 2), 1);
    end
    idle(3, 0);
    check("wait_err_before_long_wait", wait_err, 0);

    run_br(BR_BGTZ, 32'd5, 32'd0, 32'h0040_0500, 10, 0, 0);
    idle(2, 0);
    check("wait_err_after_long_wait", wait_err, 1);

    // taken BEQ flushed in its resolve cycle: nothing may come out
    br_valid = 1'b1; br_op = BR_BEQ; rs_val = 32'h9; rt_val = 32'h9;
    rs_ready = 1'b1; rt_ready = 1'b1; br_target = 32'h0040_0600; flush = 1'b1;
    #1 step();
    @(negedge clk);
    br_valid = 1'b0; flush = 1'b0;
    #1 step();
    check("flush_no_done", br_done, 0);
    check("flush_no_redirect", redirect_valid, 0);
    @(negedge clk);
    idle(2, 0);
    check("wait_err_after_flush", wait_err, 1);

`ifdef BRANCH_STATS_EN
    check("taken_cnt", taken_cnt, n_taken);
    check("ntaken_cnt", ntaken_cnt, n_ntaken);
`endif
    check("scoreboard_empty", sbq.size(), 0);

    // asynchronous reset in the middle of an operand wait
    br_valid = 1'b1; br_op = BR_BLTZ; rs_val = 32'hF000_0000; rs_ready = 1'b0;
    #1 step();
    @(negedge clk);
    #1 step();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    br_valid = 1'b0;
    #1;
    check("async_rst_stall", stall, 0);
    check("async_rst_redirect_valid", redirect_valid, 0);
    check("async_rst_redirect_pc", redirect_pc, 0);
    check("async_rst_br_done", br_done, 0);
    check("async_rst_wait_err", wait_err, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    idle(1, 0);

    // 3 taken and 2 not-taken after reset
    run_br(BR_BEQ,  32'd3, 32'd3, 32'h0000_1000, 0, 0, 0);
    run_br(BR_BGTZ, 32'd0, 32'd0, 32'h0000_2000, 1, 0, 0);
    run_br(BR_BLEZ, 32'd0, 32'd0, 32'h0000_3000, 0, 0, 0);
    run_br(BR_BNE,  32'd1, 32'd1, 32'h0000_4000, 0, 1, 0);
    run_br(BR_BLTZ, 32'hFFFF_FFF0, 32'd0, 32'h0000_5000, 0, 0, 0);
    idle(3, 0);
`ifdef BRANCH_STATS_EN
    check("taken_cnt_3", taken_cnt, 3);
    check("ntaken_cnt_2", ntaken_cnt, 2);
`endif
    check("scoreboard_empty_end", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
